counter_compare: RTL and testbench

Compare/event unit sitting directly downstream of the wrapping counter: it watches the free-running count value and raises timestamped events when the count reaches a programmed compare value. It supports one-shot and periodic operation and has a valid/ready configuration input and a single-entry valid/ready event output. Events that cannot be delivered are counted with saturation, never silently lost.

---
 rtl/counter_pkg.sv | 9 +
 rtl/counter_compare_if.sv | 27 ++
 rtl/counter_compare.sv | 129 ++++++++++++
 tb/tb_counter_compare.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types for the counter family: compare-unit state encoding.
package counter_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } state_t;

endpackage

// File: rtl/counter_compare_if.sv
// Configuration command channel and single-entry event channel of counter_compare.
interface counter_compare_if #(
   parameter int WIDTH  = 16,
   parameter int OWIDTH = 4
);

   logic              cfg_vld;
   logic              cfg_rdy;
   logic              cfg_arm;
   logic [WIDTH-1:0]  cfg_cmp;
   logic [WIDTH-1:0]  cfg_per;
   logic              evt_vld;
   logic              evt_rdy;
   logic [WIDTH-1:0]  evt_cmp;
   logic [OWIDTH-1:0] evt_ovr;

   modport master (
      output cfg_vld, cfg_arm, cfg_cmp, cfg_per, evt_rdy,
      input  cfg_rdy, evt_vld, evt_cmp, evt_ovr
   );

   modport slave (
      input  cfg_vld, cfg_arm, cfg_cmp, cfg_per, evt_rdy,
      output cfg_rdy, evt_vld, evt_cmp, evt_ovr
   );

endinterface

// File: rtl/counter_compare.sv
// Compare/event unit: raises timestamped one-shot or periodic events when the
// observed counter reaches the programmed compare value; undeliverable events are counted.
module counter_compare
   import counter_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int OWIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] cnt,
   counter_compare_if.slave bus,
   output logic             armed
);

   state_t            state_r;
   state_t            state_nxt_s;
   logic [WIDTH-1:0]  cmp_r;
   logic [WIDTH-1:0]  cmp_nxt_s;
   logic [WIDTH-1:0]  per_r;
   logic [WIDTH-1:0]  per_nxt_s;
   logic [OWIDTH-1:0] ovr_r;
   logic [OWIDTH-1:0] ovr_nxt_s;
   logic              evt_vld_r;
   logic              evt_vld_nxt_s;
   logic [WIDTH-1:0]  evt_cmp_r;
   logic [WIDTH-1:0]  evt_cmp_nxt_s;
   logic [OWIDTH-1:0] evt_ovr_r;
   logic [OWIDTH-1:0] evt_ovr_nxt_s;
   logic              cfg_xfer_s;
   logic              match_s;
   logic              pop_s;
   logic              accept_s;

   function automatic logic [OWIDTH-1:0] sat_inc(input logic [OWIDTH-1:0] v);
      if (v == {OWIDTH{1'b1}}) begin
         return v;
      end else begin
         return v + {{(OWIDTH-1){1'b0}}, 1'b1};
      end
   endfunction

   // A config transfer always wins over a match in the same cycle.
   always_comb begin
      cfg_xfer_s = bus.cfg_vld;
      match_s    = (state_r == ARMED) && (cnt == cmp_r) && !cfg_xfer_s;
      pop_s      = evt_vld_r && bus.evt_rdy;
      accept_s   = match_s && (!evt_vld_r || pop_s);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      if (cfg_xfer_s) begin
         state_nxt_s = bus.cfg_arm ? ARMED : IDLE;
      end else begin
         case (state_r)
            IDLE:    state_nxt_s = IDLE;
            ARMED:   state_nxt_s = (match_s && (per_r == {WIDTH{1'b0}})) ? IDLE : ARMED;
            default: state_nxt_s = IDLE;
         endcase
      end
   end

   // Datapath next values: compare/period reload, event buffer and overrun count.
   always_comb begin
      cmp_nxt_s     = cmp_r;
      per_nxt_s     = per_r;
      ovr_nxt_s     = ovr_r;
      evt_vld_nxt_s = evt_vld_r;
      evt_cmp_nxt_s = evt_cmp_r;
      evt_ovr_nxt_s = evt_ovr_r;
      if (cfg_xfer_s && bus.cfg_arm) begin
         cmp_nxt_s = bus.cfg_cmp;
         per_nxt_s = bus.cfg_per;
      end else if (match_s) begin
         cmp_nxt_s = cmp_r + per_r;
      end else begin
         cmp_nxt_s = cmp_r;
      end
      if (accept_s) begin
         evt_vld_nxt_s = 1'b1;
         evt_cmp_nxt_s = cmp_r;
         evt_ovr_nxt_s = ovr_r;
         ovr_nxt_s     = {OWIDTH{1'b0}};
      end else if (match_s) begin
         ovr_nxt_s = sat_inc(ovr_r);
      end else if (pop_s) begin
         evt_vld_nxt_s = 1'b0;
      end else begin
         evt_vld_nxt_s = evt_vld_r;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmp_r     <= {WIDTH{1'b0}};
         per_r     <= {WIDTH{1'b0}};
         ovr_r     <= {OWIDTH{1'b0}};
         evt_vld_r <= 1'b0;
         evt_cmp_r <= {WIDTH{1'b0}};
         evt_ovr_r <= {OWIDTH{1'b0}};
      end else begin
         cmp_r     <= cmp_nxt_s;
         per_r     <= per_nxt_s;
         ovr_r     <= ovr_nxt_s;
         evt_vld_r <= evt_vld_nxt_s;
         evt_cmp_r <= evt_cmp_nxt_s;
         evt_ovr_r <= evt_ovr_nxt_s;
      end
   end

   assign bus.cfg_rdy = 1'b1;
   assign bus.evt_vld = evt_vld_r;
   assign bus.evt_cmp = evt_cmp_r;
   assign bus.evt_ovr = evt_ovr_r;
   assign armed       = (state_r == ARMED);

endmodule

// File: tb/tb_counter_compare.sv
// Directed-vector bench for counter_compare (WIDTH=8); a second instance with
// OWIDTH=2 shares the stimulus to observe overrun saturation.
module tb_counter_compare;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] cnt;
   logic       armed_a;
   logic       armed_b;
   int         n_checks = 0;
   int         n_errors = 0;
   int         n_evt;
   logic [7:0] evq[$];

   counter_compare_if #(.WIDTH(8), .OWIDTH(4)) bus_a ();
   counter_compare_if #(.WIDTH(8), .OWIDTH(2)) bus_b ();

   assign bus_b.cfg_vld = bus_a.cfg_vld;
   assign bus_b.cfg_arm = bus_a.cfg_arm;
   assign bus_b.cfg_cmp = bus_a.cfg_cmp;
   assign bus_b.cfg_per = bus_a.cfg_per;
   assign bus_b.evt_rdy = bus_a.evt_rdy;

   counter_compare #(.WIDTH(8), .OWIDTH(4)) dut_a (
      .clk(clk), .rst(rst), .cnt(cnt), .bus(bus_a.slave), .armed(armed_a)
   );
   counter_compare #(.WIDTH(8), .OWIDTH(2)) dut_b (
      .clk(clk), .rst(rst), .cnt(cnt), .bus(bus_b.slave), .armed(armed_b)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic arm, input logic [7:0] c, input logic [7:0] p);
      bus_a.cfg_vld = 1'b1;
      bus_a.cfg_arm = arm;
      bus_a.cfg_cmp = c;
      bus_a.cfg_per = p;
      tick();
      bus_a.cfg_vld = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      cnt = 8'd0;
      bus_a.cfg_vld = 1'b0;
      bus_a.cfg_arm = 1'b0;
      bus_a.cfg_cmp = 8'd0;
      bus_a.cfg_per = 8'd0;
      bus_a.evt_rdy = 1'b1;
      tick();
      tick();
      check_eq("rst_vld", {31'd0, bus_a.evt_vld}, 32'd0);
      check_eq("rst_cmp", {24'd0, bus_a.evt_cmp}, 32'd0);
      check_eq("rst_ovr", {28'd0, bus_a.evt_ovr}, 32'd0);
      check_eq("rst_armed", {31'd0, armed_a}, 32'd0);
      check_eq("cfg_rdy", {31'd0, bus_a.cfg_rdy}, 32'd1);
      rst = 1'b0;

      // One-shot at 5 with cnt counting 0..10
      cfg(1'b1, 8'd5, 8'd0);
      check_eq("os_armed", {31'd0, armed_a}, 32'd1);
      n_evt = 0;
      for (int c = 0; c <= 10; c++) begin
         cnt = 8'(c);
         tick();
         if (bus_a.evt_vld) n_evt++;
         if (c == 5) begin
            check_eq("os_vld", {31'd0, bus_a.evt_vld}, 32'd1);
            check_eq("os_cmp", {24'd0, bus_a.evt_cmp}, 32'd5);
         end
      end
      check_eq("os_count", n_evt, 32'd1);
      check_eq("os_idle", {31'd0, armed_a}, 32'd0);

      // Periodic 250 + 10 across the wrap
      cnt = 8'd0;
      cfg(1'b1, 8'd250, 8'd10);
      for (int i = 0; i <= 275; i++) begin
         cnt = 8'(i);
         tick();
         if (bus_a.evt_vld) evq.push_back(bus_a.evt_cmp);
      end
      check_eq("per_count", evq.size(), 32'd3);
      if (evq.size() == 3) begin
         check_eq("per_ev0", {24'd0, evq[0]}, 32'd250);
         check_eq("per_ev1", {24'd0, evq[1]}, 32'd4);
         check_eq("per_ev2", {24'd0, evq[2]}, 32'd14);
      end
      cfg(1'b0, 8'd0, 8'd0);
      check_eq("per_disarm", {31'd0, armed_a}, 32'd0);

      // Overrun: 5 matches with evt_rdy low, then drain
      bus_a.evt_rdy = 1'b0;
      cnt = 8'd0;
      cfg(1'b1, 8'd3, 8'd1);
      for (int c = 3; c <= 7; c++) begin
         cnt = 8'(c);
         tick();
         if (c == 3) begin
            check_eq("ovr_first_vld", {31'd0, bus_a.evt_vld}, 32'd1);
            check_eq("ovr_first_ovr", {28'd0, bus_a.evt_ovr}, 32'd0);
         end
      end
      check_eq("ovr_hold_cmp", {24'd0, bus_a.evt_cmp}, 32'd3);
      check_eq("ovr_hold_ovr", {28'd0, bus_a.evt_ovr}, 32'd0);
      bus_a.evt_rdy = 1'b1;
      cnt = 8'd8;
      tick();
      check_eq("ovr_next_vld", {31'd0, bus_a.evt_vld}, 32'd1);
      check_eq("ovr_next_cmp", {24'd0, bus_a.evt_cmp}, 32'd8);
      check_eq("ovr_next_ovr", {28'd0, bus_a.evt_ovr}, 32'd4);
      check_eq("ovr_sat_ovr", {30'd0, bus_b.evt_ovr}, 32'd3);
      cnt = 8'd9;
      cfg(1'b0, 8'd0, 8'd0);
      check_eq("ovr_disarm_vld", {31'd0, bus_a.evt_vld}, 32'd0);
      check_eq("ovr_disarm_armed", {31'd0, armed_a}, 32'd0);

      // Stalled counter at 7, period 4
      cnt = 8'd7;
      cfg(1'b1, 8'd7, 8'd4);
      n_evt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus_a.evt_vld) begin
            n_evt++;
            check_eq("stall_cmp", {24'd0, bus_a.evt_cmp}, 32'd7);
         end
      end
      check_eq("stall_count", n_evt, 32'd1);
      cnt = 8'd11;
      tick();
      check_eq("stall_next_vld", {31'd0, bus_a.evt_vld}, 32'd1);
      check_eq("stall_next_cmp", {24'd0, bus_a.evt_cmp}, 32'd11);
      cfg(1'b0, 8'd0, 8'd0);

      // Config overrides a coincident match
      cnt = 8'd0;
      cfg(1'b1, 8'd20, 8'd0);
      cnt = 8'd20;
      cfg(1'b0, 8'd0, 8'd0);
      check_eq("dis_match_vld", {31'd0, bus_a.evt_vld}, 32'd0);
      check_eq("dis_match_armed", {31'd0, armed_a}, 32'd0);
      tick();
      check_eq("dis_idle_vld", {31'd0, bus_a.evt_vld}, 32'd0);
      cnt = 8'd0;
      cfg(1'b1, 8'd30, 8'd0);
      cnt = 8'd30;
      cfg(1'b1, 8'd40, 8'd0);
      check_eq("arm_match_vld", {31'd0, bus_a.evt_vld}, 32'd0);
      check_eq("arm_match_armed", {31'd0, armed_a}, 32'd1);
      tick();
      check_eq("arm_old_vld", {31'd0, bus_a.evt_vld}, 32'd0);
      cnt = 8'd40;
      tick();
      check_eq("arm_new_vld", {31'd0, bus_a.evt_vld}, 32'd1);
      check_eq("arm_new_cmp", {24'd0, bus_a.evt_cmp}, 32'd40);
      tick();

      // Reset with a pending event while armed
      bus_a.evt_rdy = 1'b0;
      cnt = 8'd0;
      cfg(1'b1, 8'd50, 8'd5);
      cnt = 8'd50;
      tick();
      cnt = 8'd55;
      tick();
      check_eq("pre_rst_vld", {31'd0, bus_a.evt_vld}, 32'd1);
      check_eq("pre_rst_armed", {31'd0, armed_a}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("mid_rst_vld", {31'd0, bus_a.evt_vld}, 32'd0);
      check_eq("mid_rst_armed", {31'd0, armed_a}, 32'd0);
      check_eq("mid_rst_ovr", {28'd0, bus_a.evt_ovr}, 32'd0);
      bus_a.evt_rdy = 1'b1;
      n_evt = 0;
      for (int c = 55; c <= 70; c++) begin
         cnt = 8'(c);
         tick();
         if (bus_a.evt_vld) n_evt++;
      end
      check_eq("post_rst_count", n_evt, 32'd0);
      cnt = 8'd0;
      cfg(1'b1, 8'd60, 8'd0);
      cnt = 8'd60;
      tick();
      check_eq("rearm_vld", {31'd0, bus_a.evt_vld}, 32'd1);
      check_eq("rearm_ovr", {28'd0, bus_a.evt_ovr}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
